// File: rtl/float_sub_seq_if.sv
// float_sub_seq_if: request/result bundle for the sequential float subtractor.
// The master drives start/a/b; the slave (the subtractor) returns status and result.
interface float_sub_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] diff;
    logic            overflow;
    logic            underflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, overflow, underflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, overflow, underflow
    );
endinterface

// File: rtl/float_sub_seq.sv
// float_sub_seq: multi-cycle IEEE-754 single-precision subtractor, diff = a - b.
// Exponent-0 inputs flush to zero, exponent-255 inputs return the quiet NaN 0x7FC00000.
// Working mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2] guard,
// [1] round, [0] sticky.
// Build option FSUB_RNE_EN: adds a ROUND state doing round-to-nearest-even;
// without it the mantissa is truncated and ROUND is skipped.
module float_sub_seq #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    float_sub_seq_if.slave bus
);

    localparam logic [XLEN-1:0] QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]      MAX_SHIFT = 5'd26;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
`ifdef FSUB_RNE_EN
        ROUND  = 3'd5,
`endif
        DONE   = 3'd6
    } state_t;

    state_t state, next_state;

    logic [XLEN-1:0] op_a, op_b;      // op_b already carries the inverted sign
    logic            sign_x, sign_y;
    logic [7:0]      exp_x, exp_y;
    logic [27:0]     mant_x, mant_y;
    logic [4:0]      shift_cnt;
    logic            res_sign;
    logic [7:0]      res_exp;
    logic [27:0]     res_mant;
    logic [XLEN-1:0] diff_q;
    logic            ovf_q, unf_q;
    logic            busy_c, done_c;

    logic            special, align_done, x_ge_y, add_sign, norm_ovf, norm_unf;
    logic [7:0]      exp_max;
    logic [27:0]     add_mant;

    assign special    = (op_a[30:23] == 8'hFF) || (op_b[30:23] == 8'hFF);
    assign align_done = (exp_x == exp_y) || (shift_cnt == MAX_SHIFT);
    assign exp_max    = (exp_x >= exp_y) ? exp_x : exp_y;
    // After alignment the larger-exponent operand always has the larger mantissa,
    // so a mantissa compare is enough to pick the result sign.
    assign x_ge_y     = (mant_x >= mant_y);
    assign add_mant   = (sign_x == sign_y) ? (mant_x + mant_y)
                      : (x_ge_y ? (mant_x - mant_y) : (mant_y - mant_x));
    assign add_sign   = (sign_x == sign_y) ? sign_x : (x_ge_y ? sign_x : sign_y);
    assign norm_ovf   = res_mant[27] && (res_exp == 8'd254);
    assign norm_unf   = !res_mant[27] && !res_mant[26] && (res_exp <= 8'd1);

`ifdef FSUB_RNE_EN
    logic        round_up, rnd_ovf;
    logic [24:0] rnd_mant;

    assign round_up = res_mant[2] & (res_mant[1] | res_mant[0] | res_mant[3]);
    assign rnd_mant = {1'b0, res_mant[26:3]} + {24'd0, round_up};
    assign rnd_ovf  = rnd_mant[24] && (res_exp == 8'd254);
`endif

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.diff      = diff_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and Moore status outputs.
    always_comb begin
        // NOTE: defaults first, so no branch leaves a signal unassigned and infers a latch.
        next_state = state;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        unique case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) next_state = UNPACK;
            end
            UNPACK: next_state = special ? DONE : ALIGN;
            ALIGN:  if (align_done) next_state = ADD;
            ADD:    next_state = (add_mant == 28'd0) ? DONE : NORM;
            NORM: begin
                if (res_mant[27]) begin
                    if (norm_ovf) next_state = DONE;
                end else if (res_mant[26]) begin
`ifdef FSUB_RNE_EN
                    next_state = ROUND;
`else
                    next_state = DONE;
`endif
                end else if (norm_unf) begin
                    next_state = DONE;
                end
            end
`ifdef FSUB_RNE_EN
            ROUND:  next_state = DONE;
`endif
            DONE: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, alignment, add, normalisation and result registers.
    // Result registers are written only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            sign_x    <= 1'b0;
            sign_y    <= 1'b0;
            exp_x     <= '0;
            exp_y     <= '0;
            mant_x    <= '0;
            mant_y    <= '0;
            shift_cnt <= '0;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            res_mant  <= '0;
            diff_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    op_a <= bus.a;
                    op_b <= {~bus.b[31], bus.b[30:0]};
                end
                UNPACK: begin
                    sign_x    <= op_a[31];
                    sign_y    <= op_b[31];
                    exp_x     <= op_a[30:23];
                    exp_y     <= op_b[30:23];
                    mant_x    <= (op_a[30:23] == 8'd0) ? 28'd0 : {2'b01, op_a[22:0], 3'b000};
                    mant_y    <= (op_b[30:23] == 8'd0) ? 28'd0 : {2'b01, op_b[22:0], 3'b000};
                    shift_cnt <= '0;
                    if (special) begin
                        diff_q <= QNAN;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
                    end
                end
                ALIGN: if (!align_done) begin
                    shift_cnt <= shift_cnt + 5'd1;
                    if (exp_x < exp_y) begin
                        mant_x <= {1'b0, mant_x[27:2], mant_x[1] | mant_x[0]};
                        exp_x  <= exp_x + 8'd1;
                    end else begin
                        mant_y <= {1'b0, mant_y[27:2], mant_y[1] | mant_y[0]};
                        exp_y  <= exp_y + 8'd1;
                    end
                end
                ADD: begin
                    res_sign <= add_sign;
                    res_exp  <= exp_max;
                    res_mant <= add_mant;
                    if (add_mant == 28'd0) begin
                        diff_q <= '0;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
                    end
                end
                NORM: begin
                    if (res_mant[27]) begin
                        if (norm_ovf) begin
                            diff_q <= {res_sign, 8'hFF, 23'd0};
                            ovf_q  <= 1'b1;
                            unf_q  <= 1'b0;
                        end else begin
                            res_mant <= {1'b0, res_mant[27:2], res_mant[1] | res_mant[0]};
                            res_exp  <= res_exp + 8'd1;
                        end
                    end else if (res_mant[26]) begin
`ifndef FSUB_RNE_EN
                        diff_q <= {res_sign, res_exp, res_mant[25:3]};
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
`endif
                    end else if (norm_unf) begin
                        diff_q <= '0;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b1;
                    end else begin
                        res_mant <= {res_mant[26:0], 1'b0};
                        res_exp  <= res_exp - 8'd1;
                    end
                end
`ifdef FSUB_RNE_EN
                ROUND: begin
                    unf_q <= 1'b0;
                    if (rnd_ovf) begin
                        diff_q <= {res_sign, 8'hFF, 23'd0};
                        ovf_q  <= 1'b1;
                    end else if (rnd_mant[24]) begin
                        diff_q <= {res_sign, res_exp + 8'd1, rnd_mant[23:1]};
                        ovf_q  <= 1'b0;
                    end else begin
                        diff_q <= {res_sign, res_exp, rnd_mant[22:0]};
                        ovf_q  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_sub_seq.sv
// tb_float_sub_seq: self-checking bench for float_sub_seq.
// An arithmetic reference model predicts every result; one compare process checks
// each done pulse against it and checks that results hold between done pulses.
module tb_float_sub_seq;

    typedef struct packed {
        logic [31:0] diff;
        logic        ovf;
        logic        unf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    float_sub_seq_if #(.XLEN(32)) bus ();

    float_sub_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;
    int   target   = 0;
    res_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%08h required=%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Right shift by d (capped at 26) with every lost bit folded into bit 0.
    function automatic longint shr_sticky(input longint m, input int d);
        int     k;
        longint lost;
        k    = (d > 26) ? 26 : d;
        lost = m & ((longint'(1) << k) - 1);
        return (m >> k) | ((lost != 0) ? longint'(1) : longint'(0));
    endfunction

    // Reference: signed integer arithmetic on 3-extra-bit mantissas.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        int     ea, eb, e;
        longint ma, mb, s, mag, q;
        logic   neg;
        r  = '0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            r.diff = 32'h7FC0_0000;
            return r;
        end
        ma  = (ea == 0) ? longint'(0) : (longint'(a[22:0]) + longint'(8388608)) * 8;
        mb  = (eb == 0) ? longint'(0) : (longint'(b[22:0]) + longint'(8388608)) * 8;
        e   = (ea > eb) ? ea : eb;
        ma  = shr_sticky(ma, e - ea);
        mb  = shr_sticky(mb, e - eb);
        s   = (a[31] ? -ma : ma) + (b[31] ? mb : -mb);
        if (s == 0) return r;
        neg = (s < 0);
        mag = neg ? -s : s;
        if (mag >= (longint'(1) << 27)) begin
            mag = (mag >> 1) | (mag & 1);
            e++;
            if (e >= 255) begin
                r.diff = {neg, 8'hFF, 23'd0};
                r.ovf  = 1'b1;
                return r;
            end
        end else begin
            while (mag < (longint'(1) << 26)) begin
                if (e <= 1) begin
                    r.unf = 1'b1;
                    return r;
                end
                mag = mag << 1;
                e--;
            end
        end
        q = mag >> 3;
`ifdef FSUB_RNE_EN
        if (((mag >> 2) & 1) == 1 && ((mag & 3) != 0 || (q & 1) == 1)) q++;
        if (q >= (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
            if (e >= 255) begin
                r.diff = {neg, 8'hFF, 23'd0};
                r.ovf  = 1'b1;
                return r;
            end
        end
`endif
        r.diff = {neg, e[7:0], q[22:0]};
        return r;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(model(a, b));
        target    = done_cnt + 1;
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check1("busy_after_start", bus.busy, 1'b1);
    endtask

    task automatic wait_result();
        int cnt;
        cnt = 0;
        while (done_cnt < target && cnt < 70) begin
            tick();
            cnt++;
        end
        check1("done_within_budget", done_cnt >= target, 1'b1);
        if (done_cnt < target) exp_q.delete();
        check1("latency_le_60", cnt <= 60, 1'b1);
        tick();
        check1("busy_drops_after_done", bus.busy, 1'b0);
        check1("done_single_cycle", bus.done, 1'b0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        launch(a, b);
        wait_result();
    endtask

    // Compare process: every done pulse against the model, results held otherwise.
    initial begin : compare_proc
        logic [31:0] last_diff;
        logic        last_ovf, last_unf;
        res_t        e;
        last_diff = '0;
        last_ovf  = 1'b0;
        last_unf  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_diff = '0;
                last_ovf  = 1'b0;
                last_unf  = 1'b0;
            end else if (bus.done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check1("spurious_done", bus.done, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("diff", bus.diff, e.diff);
                    check1("overflow", bus.overflow, e.ovf);
                    check1("underflow", bus.underflow, e.unf);
                    last_diff = e.diff;
                    last_ovf  = e.ovf;
                    last_unf  = e.unf;
                end
            end else begin
                check("diff_hold", bus.diff, last_diff);
                check1("overflow_hold", bus.overflow, last_ovf);
                check1("underflow_hold", bus.underflow, last_unf);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] dv_a [8];
    logic [31:0] dv_b [8];
    logic [31:0] dv_d [8];
    logic        dv_o [8];
    logic        dv_u [8];

    initial begin : main
        res_t pin;

        dv_a[0] = 32'h4040_0000; dv_b[0] = 32'h3FC0_0000; dv_d[0] = 32'h3FC0_0000; dv_o[0] = 0; dv_u[0] = 0;
        dv_a[1] = 32'h3F80_0000; dv_b[1] = 32'h3F80_0000; dv_d[1] = 32'h0000_0000; dv_o[1] = 0; dv_u[1] = 0;
        dv_a[2] = 32'h3F80_0000; dv_b[2] = 32'hBF80_0000; dv_d[2] = 32'h4000_0000; dv_o[2] = 0; dv_u[2] = 0;
        dv_a[3] = 32'h7F7F_FFFF; dv_b[3] = 32'hFF7F_FFFF; dv_d[3] = 32'h7F80_0000; dv_o[3] = 1; dv_u[3] = 0;
        dv_a[4] = 32'h0080_0001; dv_b[4] = 32'h0080_0000; dv_d[4] = 32'h0000_0000; dv_o[4] = 0; dv_u[4] = 1;
        dv_a[5] = 32'h7F80_0000; dv_b[5] = 32'h3F80_0000; dv_d[5] = 32'h7FC0_0000; dv_o[5] = 0; dv_u[5] = 0;
        dv_a[6] = 32'h0000_0000; dv_b[6] = 32'h3F80_0000; dv_d[6] = 32'hBF80_0000; dv_o[6] = 0; dv_u[6] = 0;
        // 1.0 - 2^-100: the alignment cap leaves one sticky-free LSB to subtract.
        dv_a[7] = 32'h3F80_0000; dv_b[7] = 32'h0D80_0000; dv_o[7] = 0; dv_u[7] = 0;
`ifdef FSUB_RNE_EN
        dv_d[7] = 32'h3F80_0000;
`else
        dv_d[7] = 32'h3F7F_FFFF;
`endif

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        repeat (3) tick();
        check1("reset_busy", bus.busy, 1'b0);
        check1("reset_done", bus.done, 1'b0);
        check("reset_diff", bus.diff, 32'h0);
        check1("reset_overflow", bus.overflow, 1'b0);
        check1("reset_underflow", bus.underflow, 1'b0);
        rst = 1'b0;
        tick();

        // Directed vectors: literal expectations pin the model, then the DUT runs them.
        for (int i = 0; i < 8; i++) begin
            pin = model(dv_a[i], dv_b[i]);
            check("model_pin_diff", pin.diff, dv_d[i]);
            check1("model_pin_overflow", pin.ovf, dv_o[i]);
            check1("model_pin_underflow", pin.unf, dv_u[i]);
            do_op(dv_a[i], dv_b[i]);
        end

        // start while busy must be ignored.
        launch(32'h4040_0000, 32'h3FC0_0000);
        tick();
        bus.start = 1'b1;
        bus.a     = 32'h7F7F_FFFF;
        bus.b     = 32'hFF7F_FFFF;
        tick();
        bus.start = 1'b0;
        wait_result();
        repeat (3) tick();
        check1("busy_start_ignored", bus.busy, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation after a result with overflow set.
        do_op(32'h7F7F_FFFF, 32'hFF7F_FFFF);
        launch(32'h4040_0000, 32'h3FC0_0000);
        check1("busy_before_abort", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check1("abort_busy", bus.busy, 1'b0);
        check1("abort_done", bus.done, 1'b0);
        check("abort_diff", bus.diff, 32'h0);
        check1("abort_overflow", bus.overflow, 1'b0);
        check1("abort_underflow", bus.underflow, 1'b0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check1("idle_after_abort", bus.busy, 1'b0);
        do_op(32'h4040_0000, 32'h3FC0_0000);

        // Randomised operands, biased toward cancellation, overflow and underflow.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            int          mode, ex;
            ra   = $urandom;
            rb   = $urandom;
            mode = int'($urandom_range(0, 5));
            case (mode)
                1: begin
                    if (ra[30:23] == 8'hFF) ra[30:23] = 8'd128;
                    ex = int'(ra[30:23]) + int'($urandom_range(0, 6)) - 3;
                    if (ex < 1)   ex = 1;
                    if (ex > 254) ex = 254;
                    rb[30:23] = ex[7:0];
                end
                2: begin
                    if (ra[30:23] == 8'hFF) ra[30:23] = 8'd100;
                    rb     = ra ^ ($urandom & 32'h0000_03FF);
                    rb[31] = ra[31];
                end
                3: begin
                    if ($urandom_range(0, 1) == 1) ra[30:23] = 8'd0;
                    else                           rb[30:23] = 8'd0;
                    if (ra[30:23] == 8'hFF) ra[30:23] = 8'd1;
                    if (rb[30:23] == 8'hFF) rb[30:23] = 8'd1;
                end
                4: begin
                    ra[30:23] = 8'(254 - $urandom_range(0, 1));
                    rb[30:23] = 8'(254 - $urandom_range(0, 1));
                    rb[31]    = ~ra[31];
                end
                5: begin
                    ra[30:23] = 8'($urandom_range(1, 3));
                    rb        = ra ^ ($urandom & 32'h0000_FFFF);
                    rb[30:23] = 8'($urandom_range(1, 3));
                    rb[31]    = ra[31];
                end
                default: ;
            endcase
            do_op(ra, rb);
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
